vga_timing_gen: RTL and testbench

Generates the 800x600@60 Hz raster timing bus (counters, syncs, blanks, frame pulse) that heads the video pipeline. Its outputs are packed into the timing word that the downstream fixed-latency delay stage carries alongside the draw stages. The block is a pair of cascaded counters with registered decode, advancing only on a pixel-enable strobe.

---
 rtl/vga_timing_gen_pkg.sv | 37 +++
 rtl/vga_timing_gen_if.sv | 39 +++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_pkg
// Purpose  : Shared video constants: default 800x600@60 raster timing, counter
//            width, timing-word width and the field offsets used to pack and
//            unpack the timing word {vcount, vsync, vblnk, hcount, hsync, hblnk}.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FRONT   = 40;
    localparam int VGA_H_SYNC    = 128;
    localparam int VGA_H_BACK    = 88;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FRONT   = 1;
    localparam int VGA_V_SYNC    = 4;
    localparam int VGA_V_BACK    = 23;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam bit VGA_SYNC_POL  = 1'b1;
    localparam int VGA_CW        = 11;

    // Timing word, LSB first: hblnk, hsync, hcount, vblnk, vsync, vcount
    localparam int VGA_TW         = 2 * VGA_CW + 4;
    localparam int VGA_HBLNK_OFS  = 0;
    localparam int VGA_HSYNC_OFS  = 1;
    localparam int VGA_HCOUNT_OFS = 2;
    localparam int VGA_VBLNK_OFS  = VGA_CW + 2;
    localparam int VGA_VSYNC_OFS  = VGA_CW + 3;
    localparam int VGA_VCOUNT_OFS = VGA_CW + 4;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Purpose  : Raster timing bus. The generator (master) receives the pixel
//            strobe and drives counters, syncs, blanks and the frame pulse;
//            consumers (slave) see the same signals plus the packed word.
// Signals  : pix_en, hcount[CW], vcount[CW], hsync, vsync, hblnk, vblnk,
//            frame_start, tword[2*CW+4]
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if
    import vga_timing_gen_pkg::*;
#(
    parameter int CW = VGA_CW
);
    logic          pix_en;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          hblnk;
    logic          vblnk;
    logic          frame_start;
    logic [2*CW+3:0] tword;

    // Packed form carried by the downstream delay stage
    assign tword = {vcount, vsync, vblnk, hcount, hsync, hblnk};

    modport master (
        input  pix_en,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
    );

    modport slave (
        output pix_en,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, tword
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster timing generator. Cascaded horizontal/vertical counters
//            advancing on pix_en, with sync/blank decoded from the next count
//            so every output is a flop aligned with the count it describes.
// Ports    : clk  - pixel clock
//            rst  - synchronous active-high reset (dominates pix_en)
//            tmg  - timing bus (master): pix_en in; hcount, vcount, hsync,
//                   vsync, hblnk, vblnk, frame_start out
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit SYNC_POL  = VGA_SYNC_POL,
    parameter int CW        = VGA_CW
)(
    input  wire logic          clk,
    input  wire logic          rst,
    vga_timing_gen_if.master   tmg
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] c_H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] c_H_VIS      = CW'(H_VISIBLE);
    localparam logic [CW-1:0] c_H_SYNC_ON  = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] c_H_SYNC_OFF = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] c_V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] c_V_VIS      = CW'(V_VISIBLE);
    localparam logic [CW-1:0] c_V_SYNC_ON  = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] c_V_SYNC_OFF = CW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          hsync_q,  hsync_d;
    logic          vsync_q,  vsync_d;
    logic          hblnk_q,  hblnk_d;
    logic          vblnk_q,  vblnk_d;
    logic          frame_q,  frame_d;
    logic          w_h_wrap;
    logic          w_v_wrap;

    // Next-state and decode. Sync/blank look at the *next* counts so the
    // registered versions line up with the registered counters.
    always_comb begin
        w_h_wrap = (hcount_q == c_H_LAST);
        w_v_wrap = (vcount_q == c_V_LAST);

        hcount_d = w_h_wrap ? '0 : hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (w_h_wrap) begin
            vcount_d = w_v_wrap ? '0 : vcount_q + 1'b1;
        end

        hblnk_d = (hcount_d >= c_H_VIS);
        vblnk_d = (vcount_d >= c_V_VIS);
        hsync_d = ((hcount_d >= c_H_SYNC_ON) && (hcount_d < c_H_SYNC_OFF)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vcount_d >= c_V_SYNC_ON) && (vcount_d < c_V_SYNC_OFF)) ? SYNC_POL : ~SYNC_POL;

        // Entering (0,0) from the last pixel of the last line
        frame_d = w_h_wrap & w_v_wrap;
    end

    // Horizontal counter and decode
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            hblnk_q  <= 1'b0;
            hsync_q  <= ~SYNC_POL;
        end else if (tmg.pix_en) begin
            hcount_q <= hcount_d;
            hblnk_q  <= hblnk_d;
            hsync_q  <= hsync_d;
        end
    end

    // Vertical counter, decode and frame pulse. The pulse is cleared on any
    // non-strobe cycle so it is never wider than one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcount_q <= '0;
            vblnk_q  <= 1'b0;
            vsync_q  <= ~SYNC_POL;
            frame_q  <= 1'b0;
        end else begin
            frame_q <= tmg.pix_en & frame_d;
            if (tmg.pix_en) begin
                vcount_q <= vcount_d;
                vblnk_q  <= vblnk_d;
                vsync_q  <= vsync_d;
            end
        end
    end

    assign tmg.hcount      = hcount_q;
    assign tmg.vcount      = vcount_q;
    assign tmg.hsync       = hsync_q;
    assign tmg.vsync       = vsync_q;
    assign tmg.hblnk       = hblnk_q;
    assign tmg.vblnk       = vblnk_q;
    assign tmg.frame_start = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench. Instance A uses the default 800x600 timing,
//            instance B a tiny active-low override (H 8/1/2/1, V 4/1/1/1).
//            Expected outputs come from the count of enabled cycles since
//            reset, converted to a raster position with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int B_HV = 8, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VV = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_HT = B_HV + B_HF + B_HS + B_HB;   // 12
    localparam int B_VT = B_VV + B_VF + B_VS + B_VB;   // 7
    localparam int B_CW = 4;
    localparam longint FRAME_A = longint'(VGA_H_TOTAL) * VGA_V_TOTAL;
    localparam longint FRAME_B = longint'(B_HT) * B_VT;  // 84

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    vga_timing_gen_if #(.CW(VGA_CW)) ifa ();
    vga_timing_gen_if #(.CW(B_CW))   ifb ();

    vga_timing_gen u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .tmg (ifa)
    );

    vga_timing_gen #(
        .H_VISIBLE (B_HV), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_VISIBLE (B_VV), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
        .SYNC_POL  (1'b0), .CW      (B_CW)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .tmg (ifb)
    );

    int     vectors    = 0;
    int     miscompares = 0;
    int     cyc        = 0;
    longint n_a = 0, n_b = 0;      // enabled cycles since reset
    bit     fs_a = 0, fs_b = 0;    // expected frame_start

    typedef struct {
        int h; int v; bit hs; bit vs; bit hb; bit vb;
    } pos_t;

    // Raster position n enabled pixels after reset
    function automatic pos_t ref_pos(longint n, int hv, int hf, int hs, int hbp,
                                     int vv, int vf, int vs, int vbp, bit pol);
        pos_t p;
        int ht = hv + hf + hs + hbp;
        int vt = vv + vf + vs + vbp;
        p.h  = int'(n % ht);
        p.v  = int'((n / ht) % vt);
        p.hb = (p.h >= hv);
        p.vb = (p.v >= vv);
        p.hs = (p.h >= hv + hf && p.h < hv + hf + hs) ? pol : !pol;
        p.vs = (p.v >= vv + vf && p.v < vv + vf + vs) ? pol : !pol;
        return p;
    endfunction

    function automatic logic [2*VGA_CW+4:0] exp_a();
        pos_t p = ref_pos(n_a, VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK,
                          VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK, 1'b1);
        return {VGA_CW'(p.h), VGA_CW'(p.v), p.hs, p.vs, p.hb, p.vb, fs_a};
    endfunction

    function automatic logic [2*B_CW+4:0] exp_b();
        pos_t p = ref_pos(n_b, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1'b0);
        return {B_CW'(p.h), B_CW'(p.v), p.hs, p.vs, p.hb, p.vb, fs_b};
    endfunction

    function automatic logic [2*VGA_CW+4:0] obs_a();
        return {ifa.hcount, ifa.vcount, ifa.hsync, ifa.vsync, ifa.hblnk, ifa.vblnk, ifa.frame_start};
    endfunction

    function automatic logic [2*B_CW+4:0] obs_b();
        return {ifb.hcount, ifb.vcount, ifb.hsync, ifb.vsync, ifb.hblnk, ifb.vblnk, ifb.frame_start};
    endfunction

    // One clock for both instances; updates the reference counts
    task automatic step(input bit ra, input bit ea, input bit rb, input bit eb);
        rst_a = ra; ifa.pix_en = ea;
        rst_b = rb; ifb.pix_en = eb;
        @(posedge clk);
        #1;
        cyc++;
        if (ra)      begin n_a = 0; fs_a = 0; end
        else if (ea) begin n_a++; fs_a = (n_a % FRAME_A) == 0; end
        else         fs_a = 0;
        if (rb)      begin n_b = 0; fs_b = 0; end
        else if (eb) begin n_b++; fs_b = (n_b % FRAME_B) == 0; end
        else         fs_b = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
        vectors++;
        if (obs_a() !== '0) begin
            miscompares++;
            $display("FAIL reset_a got=%h want=%h", obs_a(), 27'h0);
        end
        vectors++;
        if (obs_b() !== 13'b0000_0000_11000) begin
            miscompares++;
            $display("FAIL reset_b got=%b want=%b", obs_b(), 13'b0000_0000_11000);
        end
        step(0, 1, 0, 1);
        vectors++;
        if (ifa.hcount !== 11'd1 || ifa.vcount !== 11'd0 || ifa.frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL first_step_a got h=%0d v=%0d fs=%b want h=1 v=0 fs=0",
                     ifa.hcount, ifa.vcount, ifa.frame_start);
        end
        vectors++;
        if (ifb.hcount !== 4'd1 || ifb.vcount !== 4'd0 || ifb.frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL first_step_b got h=%0d v=%0d fs=%b want h=1 v=0 fs=0",
                     ifb.hcount, ifb.vcount, ifb.frame_start);
        end
    endtask

    task automatic test_line_a();
        int hs_cnt = 0;
        int first_hb = -1;
        int wrap_h = -1;
        for (int i = 0; i < 2 * VGA_H_TOTAL + 20; i++) begin
            step(0, 1, 0, 0);
            vectors++;
            if (obs_a() !== exp_a()) begin
                miscompares++;
                $display("FAIL line_a cyc=%0d got=%h want=%h", cyc, obs_a(), exp_a());
            end
            if (ifa.vcount == 0 && ifa.hsync === 1'b1) hs_cnt++;
            if (first_hb < 0 && ifa.hblnk === 1'b1) first_hb = int'(ifa.hcount);
            if (wrap_h < 0 && ifa.vcount == 1) wrap_h = int'(ifa.hcount);
        end
        vectors++;
        if (hs_cnt != VGA_H_SYNC) begin
            miscompares++;
            $display("FAIL hsync_width_a got=%0d want=%0d", hs_cnt, VGA_H_SYNC);
        end
        vectors++;
        if (first_hb != VGA_H_VISIBLE) begin
            miscompares++;
            $display("FAIL hblnk_rise_a got=%0d want=%0d", first_hb, VGA_H_VISIBLE);
        end
        vectors++;
        if (wrap_h != 0) begin
            miscompares++;
            $display("FAIL vwrap_hcount_a got=%0d want=0", wrap_h);
        end
    endtask

    task automatic test_frame_b();
        int fs_cnt = 0, vs_cnt = 0, hs_cnt = 0;
        step(0, 0, 1, 1);
        for (int i = 0; i < 3 * int'(FRAME_B); i++) begin
            step(0, 0, 0, 1);
            vectors++;
            if (obs_b() !== exp_b()) begin
                miscompares++;
                $display("FAIL frame_b cyc=%0d got=%h want=%h", cyc, obs_b(), exp_b());
            end
            if (ifb.frame_start === 1'b1) fs_cnt++;
            if (ifb.vsync === 1'b0) vs_cnt++;
            if (ifb.hsync === 1'b0) hs_cnt++;
        end
        vectors++;
        if (fs_cnt != 3) begin
            miscompares++;
            $display("FAIL frame_count_b got=%0d want=3", fs_cnt);
        end
        vectors++;
        if (vs_cnt != 36 || hs_cnt != 42) begin
            miscompares++;
            $display("FAIL sync_cycles_b got vs=%0d hs=%0d want vs=36 hs=42", vs_cnt, hs_cnt);
        end
    endtask

    task automatic test_random_b();
        for (int i = 0; i < 400; i++) begin
            step(0, 0, 0, 1'($urandom_range(0, 1)));
            vectors++;
            if (obs_b() !== exp_b()) begin
                miscompares++;
                $display("FAIL random_b cyc=%0d got=%h want=%h", cyc, obs_b(), exp_b());
            end
        end
    endtask

    task automatic test_half_rate_b();
        int p1 = -1, p2 = -1;
        bit prev_fs = 0, wide = 0;
        step(0, 0, 1, 0);
        for (int i = 0; i < 2 * 2 * int'(FRAME_B) + 4; i++) begin
            step(0, 0, 0, (i % 2) == 0);
            vectors++;
            if (obs_b() !== exp_b()) begin
                miscompares++;
                $display("FAIL half_rate_b cyc=%0d got=%h want=%h", cyc, obs_b(), exp_b());
            end
            if (ifb.frame_start === 1'b1) begin
                if (prev_fs) wide = 1;
                if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
            end
            prev_fs = (ifb.frame_start === 1'b1);
        end
        vectors++;
        if (p1 != 2 * int'(FRAME_B) - 2 || p2 - p1 != 2 * int'(FRAME_B) || wide) begin
            miscompares++;
            $display("FAIL half_rate_period_b got p1=%0d period=%0d wide=%0d want p1=%0d period=%0d wide=0",
                     p1, p2 - p1, wide, 2 * int'(FRAME_B) - 2, 2 * int'(FRAME_B));
        end
    endtask

    task automatic test_mid_reset();
        step(0, 0, 1, 0);
        for (int i = 0; i < 5 * B_HT + 9; i++) step(0, 0, 0, 1);
        vectors++;
        if (ifb.hcount !== 4'd9 || ifb.vcount !== 4'd5 || ifb.hsync !== 1'b0 || ifb.vsync !== 1'b0) begin
            miscompares++;
            $display("FAIL in_sync_b got h=%0d v=%0d hs=%b vs=%b want h=9 v=5 hs=0 vs=0",
                     ifb.hcount, ifb.vcount, ifb.hsync, ifb.vsync);
        end
        step(0, 0, 1, 1);
        vectors++;
        if (obs_b() !== 13'b0000_0000_11000) begin
            miscompares++;
            $display("FAIL mid_reset_b got=%b want=%b", obs_b(), 13'b0000_0000_11000);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (ifb.hcount !== 4'd1 || ifb.vcount !== 4'd0) begin
            miscompares++;
            $display("FAIL resume_b got h=%0d v=%0d want h=1 v=0", ifb.hcount, ifb.vcount);
        end

        step(1, 0, 0, 0);
        for (int i = 0; i < 900; i++) step(0, 1, 0, 0);
        vectors++;
        if (ifa.hcount !== 11'd900 || ifa.hsync !== 1'b1 || ifa.hblnk !== 1'b1) begin
            miscompares++;
            $display("FAIL in_hsync_a got h=%0d hs=%b hb=%b want h=900 hs=1 hb=1",
                     ifa.hcount, ifa.hsync, ifa.hblnk);
        end
        step(1, 1, 0, 0);
        vectors++;
        if (obs_a() !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_a got=%h want=%h", obs_a(), 27'h0);
        end
        step(0, 1, 0, 0);
        vectors++;
        if (ifa.hcount !== 11'd1 || ifa.vcount !== 11'd0) begin
            miscompares++;
            $display("FAIL resume_a got h=%0d v=%0d want h=1 v=0", ifa.hcount, ifa.vcount);
        end
    endtask

    task automatic test_tword_a();
        logic [VGA_TW-1:0] tw;
        pos_t p;
        for (int k = 0; k < 4; k++) begin
            int len = int'($urandom_range(1, 1500));
            for (int i = 0; i < len; i++) step(0, 1'($urandom_range(0, 3) != 0), 0, 0);
            tw = ifa.tword;
            p = ref_pos(n_a, VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK,
                        VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK, 1'b1);
            vectors++;
            if (tw[VGA_HCOUNT_OFS +: VGA_CW] !== VGA_CW'(p.h) || tw[VGA_VCOUNT_OFS +: VGA_CW] !== VGA_CW'(p.v) ||
                tw[VGA_HSYNC_OFS] !== p.hs || tw[VGA_VSYNC_OFS] !== p.vs ||
                tw[VGA_HBLNK_OFS] !== p.hb || tw[VGA_VBLNK_OFS] !== p.vb) begin
                miscompares++;
                $display("FAIL tword_a cyc=%0d got=%h want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                         cyc, tw, p.h, p.v, p.hs, p.vs, p.hb, p.vb);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.pix_en = 1'b0; ifb.pix_en = 1'b0;
        #1;
        test_reset();
        test_line_a();
        test_frame_b();
        test_random_b();
        test_half_rate_b();
        test_mid_reset();
        test_tword_a();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
